mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage data access controller. Sits directly downstream of the MIPS address mapping unit.
- Consumes the physical address that unit produces and drives the sram-like data bus: req/addr_ok/data_ok handshake.
- Generates byte strobes and replicated write data, and detects misaligned accesses.
- Extracts and extends load data, and holds the pipeline with stall_o until each access completes.

Parameters:
- None. The 32-bit address and data paths are fixed by the ISA.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  MEM stage presents a load or store this cycle.
- req_wr_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- req_sign_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_paddr_i  in  32  physical address from the mapping unit.
- req_wdata_i  in  32  store data, right-aligned.
- flush_i  in  1  exception/flush: cancel the in-flight response.
- data_sram_req  out  1  bus request.
- data_sram_wr  out  1  bus write.
- data_sram_size  out  2  bus size: 0, 1 or 2.
- data_sram_addr  out  32  bus address (latched physical address).
- data_sram_wstrb  out  4  byte strobes.
- data_sram_wdata  out  32  replicated write data.
- data_sram_addr_ok  in  1  bus accepted the request.
- data_sram_data_ok  in  1  bus completed; rdata valid.
- data_sram_rdata  in  32  bus read data.
- stall_o  out  1  hold the pipeline.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load result; 0 for stores.
- adel_o  out  1  load address misaligned (combinational).
- ades_o  out  1  store address misaligned (combinational).

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset enters IDLE and clears all registers.
- Reset values: data_sram_req, resp_valid_o, stall_o, adel_o and ades_o are 0. resp_rdata_o and all bus fields are 0.
- Misalignment: half with paddr[0]=1, or word with paddr[1:0]≠0.
  - Evaluated only in IDLE with req_valid_i=1 and flush_i=0.
  - Raises adel_o or ades_o that same cycle.
  - No bus request is issued, stall_o stays 0, and the state stays IDLE.
- IDLE: with req_valid_i=1, aligned access and flush_i=0:
  - Latch wr, size, sign, paddr[1:0], address, strobes and wdata.
  - Set stall_o=1 combinationally and go to REQ.
- Strobes (stores):
  - Byte: wstrb = 4'b0001 << paddr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: wstrb = paddr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111, wdata passed through.
  - Loads: wstrb = 0.
- REQ:
  - data_sram_req=1 and stall_o=1.
  - All bus fields stay stable until addr_ok.
  - On addr_ok, go to WAIT.
  - data_sram_req is never withdrawn before addr_ok, even under flush.
- WAIT:
  - data_sram_req=0 and stall_o=1.
  - data_ok is honoured only in WAIT.
  - On data_ok, register resp_rdata_o = extend(rdata >> 8*paddr[1:0], size, sign) and go to DONE.
  - Stores register resp_rdata_o=0.
- DONE:
  - resp_valid_o=1 and stall_o=0 for exactly one cycle, then IDLE.
  - req_valid_i in DONE is the just-completed instruction and is ignored.
- Flush:
  - A drop flag is set by flush_i in REQ, WAIT or DONE, and cleared on return to IDLE.
  - The bus transaction still runs to data_ok (stores are committed).
  - If the flag is set at data_ok, go directly to IDLE. No DONE state occurs and resp_valid_o stays 0.
  - stall_o keeps the behaviour defined by state regardless of flush.
- Only one outstanding transaction at a time.
- Reset mid-transaction returns to IDLE immediately. A late data_ok arriving in IDLE is ignored.

Test Plan:
- Word load at 0x0000_1004, addr_ok on cycle 2, data_ok 3 cycles later with rdata 0xDEADBEEF:
  - data_sram_req is high exactly until addr_ok, with size=2 and wstrb=0.
  - resp_valid_o pulses one cycle with 0xDEADBEEF.
  - stall_o is high from the accept cycle through WAIT.
- Signed byte load at 0x...1003, rdata 0x80112233:
  - resp_rdata_o = 0xFFFFFF80.
  - The unsigned version gives 0x00000080.
- Half store of 0x0000ABCD at 0x...1002:
  - wstrb = 4'b1100, wdata = 0xABCDABCD, data_sram_wr=1.
  - resp_rdata_o = 0.
- Word load at 0x...1002:
  - adel_o=1 for one cycle, data_sram_req never rises, stall_o=0.
  - The same case as a half store at 0x...1001 gives ades_o=1.
- flush_i asserted during WAIT of a load:
  - data_ok is consumed and resp_valid_o never pulses.
  - The controller is in IDLE the next cycle.
  - A new load is accepted immediately after.
- rst asserted in REQ:
  - The next cycle has data_sram_req=0 and stall_o=0.
  - A subsequent stray data_ok produces no response.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage data access controller: drives the sram-like data bus for one
// load/store at a time, builds strobes/replicated write data and extends load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic [31:0] req_paddr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        adel_o,
  output logic        ades_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        drop_q;
  logic        wr_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        check_en;
  logic        misalign;
  logic        accept;
  logic [1:0]  size_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] rdata_d;

  assign check_en = (state_q == S_IDLE) && req_valid_i && !flush_i && !rst;
  // Size 3 is reserved and behaves as a word, so size_i[1] covers both.
  assign misalign = (req_size_i == 2'd1 && req_paddr_i[0]) ||
                    (req_size_i[1] && (req_paddr_i[1:0] != 2'b00));
  assign accept   = check_en && !misalign;
  assign adel_o   = check_en && misalign && !req_wr_i;
  assign ades_o   = check_en && misalign && req_wr_i;

  always_comb begin
    size_d  = req_size_i[1] ? 2'd2 : req_size_i;
    wstrb_d = '0;
    wdata_d = req_wdata_i;
    case (size_d)
      2'd0: begin
        wstrb_d = 4'b0001 << req_paddr_i[1:0];
        wdata_d = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        wstrb_d = req_paddr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata_i[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!req_wr_i) wstrb_d = '0;
  end

  always_comb begin
    shifted = data_sram_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rdata_d = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'd1:    rdata_d = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: rdata_d = shifted;
    endcase
    if (wr_q) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          drop_q <= 1'b0;
          if (accept) begin
            wr_q    <= req_wr_i;
            sign_q  <= req_sign_i;
            size_q  <= size_d;
            off_q   <= req_paddr_i[1:0];
            addr_q  <= req_paddr_i;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush_i) drop_q <= 1'b1;
          if (data_sram_addr_ok) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          // A flush in the data_ok cycle itself also suppresses the response.
          if (data_sram_data_ok) begin
            rdata_q <= rdata_d;
            state_q <= (drop_q || flush_i) ? S_IDLE : S_DONE;
          end
        end
        default: begin
          drop_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;
  assign stall_o         = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  assign resp_valid_o    = (state_q == S_DONE);
  assign resp_rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver issues accesses, a bus responder
// checks bus fields and answers, and a monitor checks each completion pulse.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_wr_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_sign_i = 1'b0;
  logic [31:0] req_paddr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        flush_i = 1'b0;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        adel_o;
  logic        ades_o;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_size_i(req_size_i),
    .req_sign_i(req_sign_i), .req_paddr_i(req_paddr_i), .req_wdata_i(req_wdata_i),
    .flush_i(flush_i),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .stall_o(stall_o), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .adel_o(adel_o), .ades_o(ades_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned a;
    int unsigned d;
    int unsigned f;
    bit          fen;
    bit          stray;
  } desc_t;

  desc_t       desc_q[$];
  logic [31:0] exp_q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic int unsigned nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit misal(logic [31:0] a, logic [1:0] s);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] ref_strb(logic [31:0] a, logic [1:0] s, logic wr);
    logic [3:0] r = '0;
    if (wr)
      for (int i = 0; i < int'(nbytes(s)); i++) r[int'(a % 4) + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] ref_wdata(logic [31:0] w, logic [1:0] s);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = w[8*(j % int'(nbytes(s))) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] rd, logic [31:0] a,
                                           logic [1:0] s, logic sg);
    longint      v = 0;
    int          n = int'(nbytes(s));
    int          off = int'(a % 4);
    logic [63:0] t;
    for (int i = 0; i < n; i++) v += longint'(rd[8*(off + i) +: 8]) << (8*i);
    if (sg && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    t = 64'(v);
    return t[31:0];
  endfunction

  // Bus responder: one descriptor per accepted access, consumed on req.
  initial begin
    desc_t       cur;
    int unsigned phase = 0;
    int unsigned cnt = 0;
    forever begin
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      flush_i = 1'b0;
      if (phase == 0 && data_sram_req) begin
        if (desc_q.size() == 0) check1("unexpected_req", data_sram_req, 1'b0);
        else begin
          cur = desc_q.pop_front();
          phase = 1;
          cnt = 0;
        end
      end
      if (phase == 1) begin
        if (!data_sram_req) phase = cur.stray ? 4 : 0;
        else begin
          check("bus_addr", data_sram_addr, cur.addr);
          check1("bus_wr", data_sram_wr, cur.wr);
          check("bus_size", 32'(data_sram_size), 32'(cur.size));
          check("bus_wstrb", 32'(data_sram_wstrb), 32'(cur.wstrb));
          if (cur.wr) check("bus_wdata", data_sram_wdata, cur.wdata);
          check1("stall_req", stall_o, 1'b1);
          if (cnt == cur.a) begin
            data_sram_addr_ok = 1'b1;
            phase = 2;
            cnt = 0;
          end else cnt++;
        end
      end else if (phase == 2) begin
        check1("req_after_addr_ok", data_sram_req, 1'b0);
        check1("stall_wait", stall_o, 1'b1);
        if (cur.fen && cnt == cur.f) flush_i = 1'b1;
        if (cnt == cur.d) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata = cur.rdata;
          phase = 0;
        end else cnt++;
      end else if (phase == 4) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata = $urandom;
        phase = 0;
      end
    end
  end

  // Monitor: every completion pulse must match the next expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid_o) begin
        check1("stall_done", stall_o, 1'b0);
        if (exp_q.size() == 0) check1("unexpected_resp", resp_valid_o, 1'b0);
        else check("resp_rdata", resp_rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic access(input logic wr, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int unsigned a,
                        input int unsigned d, input bit fen, input int unsigned f,
                        input bit kill, input bit stray);
    desc_t       ds;
    int unsigned n;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wr_i = wr;
    req_size_i = size;
    req_sign_i = sign;
    req_paddr_i = addr;
    req_wdata_i = wdata;
    #1;
    if (misal(addr, size)) begin
      check1("adel", adel_o, !wr);
      check1("ades", ades_o, wr);
      check1("stall_misaligned", stall_o, 1'b0);
      @(negedge clk);
      req_valid_i = 1'b0;
      #1;
      check1("req_misaligned", data_sram_req, 1'b0);
      check1("stall_after_misaligned", stall_o, 1'b0);
      check1("adel_cleared", adel_o, 1'b0);
      return;
    end
    check1("stall_accept", stall_o, 1'b1);
    check1("no_exc", adel_o | ades_o, 1'b0);
    ds.addr = addr;
    ds.wr = wr;
    ds.size = (size == 2'd3) ? 2'd2 : size;
    ds.wstrb = ref_strb(addr, size, wr);
    ds.wdata = ref_wdata(wdata, size);
    ds.rdata = rdata;
    ds.a = a;
    ds.d = d;
    ds.f = f;
    ds.fen = fen;
    ds.stray = stray;
    desc_q.push_back(ds);
    if (!fen && !kill) exp_q.push_back(wr ? 32'h0 : ref_load(rdata, addr, size, sign));
    @(negedge clk);
    req_valid_i = 1'b0;
    if (kill) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check1("req_after_reset", data_sram_req, 1'b0);
      check1("stall_after_reset", stall_o, 1'b0);
      check("addr_after_reset", data_sram_addr, 32'h0);
      repeat (4) @(negedge clk);
      return;
    end
    n = 0;
    while (stall_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1("completes_in_time", stall_o, 1'b0);
    if (resp_valid_o) @(negedge clk);
  endtask

  initial begin
    int unsigned d;
    bit          fen;
    logic [1:0]  sz;
    logic [31:0] ad;
    repeat (3) @(negedge clk);
    check1("rst_req", data_sram_req, 1'b0);
    check1("rst_stall", stall_o, 1'b0);
    check1("rst_resp_valid", resp_valid_o, 1'b0);
    check1("rst_adel", adel_o, 1'b0);
    check1("rst_ades", ades_o, 1'b0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    check("rst_wstrb", 32'(data_sram_wstrb), 32'h0);
    rst = 1'b0;

    access(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, 2, 0, 0, 0, 0);
    access(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 1, 0, 0, 0, 0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h8011_2233, 2, 0, 0, 0, 0, 0);
    access(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    access(1'b1, 2'd1, 1'b0, 32'h0000_1001, 32'h1111_2222, 32'h0, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1, 3, 1, 1, 0, 0);
    access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 0, 1, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 40, 0, 0, 0, 1, 1);
    access(1'b1, 2'd3, 1'b0, 32'h0000_3008, 32'h0102_0304, 32'h0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = ad[1:0] & ~2'(nbytes(sz) - 1);
      d = $urandom_range(0, 4);
      fen = (d >= 1) && ($urandom_range(0, 3) == 0);
      access(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom,
             $urandom_range(0, 3), d, fen, fen ? $urandom_range(0, d - 1) : 0, 0, 0);
    end

    repeat (10) @(negedge clk);
    check("responses_outstanding", exp_q.size(), 0);
    check("bus_txns_outstanding", desc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
